// File: rtl/rv32_pkg.sv
// Shared RV32I core definitions: architectural widths, load funct3 encodings
// and the writeback FSM state type.
package rv32_pkg;

    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_FILE_SIZE  = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [0:0] {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/regfile_writeback_load_align.sv
// Combinational load formatter: selects the byte/halfword lane addressed by
// offset, sign- or zero-extends it, and flags misaligned accesses.
module load_align #(
    parameter int XLEN = rv32_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);
    import rv32_pkg::*;

    function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] v);
        return {{(XLEN-8){v[7]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext8(input logic signed [7:0] v);
        return {{(XLEN-8){1'b0}}, v};
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] v);
        return {{(XLEN-16){v[15]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic signed [15:0] v);
        return {{(XLEN-16){1'b0}}, v};
    endfunction

    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Reserved encodings fall through to the word path.
    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (funct3)
            LB:  data = sext8(byte_sel);
            LBU: data = zext8(byte_sel);
            LH: begin
                data       = sext16(half_sel);
                misaligned = offset[0];
            end
            LHU: begin
                data       = zext16(half_sel);
                misaligned = offset[0];
            end
            default: begin
                data       = rdata;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/regfile_writeback.sv
// Regfile write-port master: merges ALU results and formatted load data and
// keeps the pending-load scoreboard. Optional macro WB_FWD_EN adds forwarding.
module regfile_writeback #(
    parameter int XLEN           = rv32_pkg::XLEN,
    parameter int REG_ADDR_WIDTH = rv32_pkg::REG_ADDR_WIDTH,
    parameter int REG_FILE_SIZE  = rv32_pkg::REG_FILE_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
    input  logic [2:0]                ld_funct3,
    input  logic [1:0]                ld_offset,
    input  logic                      mem_rvalid,
    input  logic [XLEN-1:0]           mem_rdata,
`ifdef WB_FWD_EN
    input  logic [REG_ADDR_WIDTH-1:0] r1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] r2_addr,
    output logic                      r1_fwd_valid,
    output logic                      r2_fwd_valid,
    output logic [XLEN-1:0]           r1_fwd_data,
    output logic [XLEN-1:0]           r2_fwd_data,
`endif
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [XLEN-1:0]           rd_data,
    output logic                      write_en,
    output logic [REG_FILE_SIZE-1:0]  busy_mask,
    output logic                      ld_err
);
    import rv32_pkg::*;

    wb_state_t                 state;
    logic [REG_ADDR_WIDTH-1:0] ld_rd_p1;
    logic [2:0]                ld_funct3_p1;
    logic [1:0]                ld_offset_p1;

    logic [XLEN-1:0] fmt_data;
    logic            fmt_mis;
    logic            in_wait;
    logic            ld_done;
    logic            waw_stall;
    logic            ld_accept;
    logic            alu_accept;

    assign in_wait    = (state == WB_WAIT_MEM);
    assign ld_done    = in_wait && mem_rvalid;
    assign waw_stall  = in_wait && (alu_rd == ld_rd_p1) && (alu_rd != '0);
    assign alu_ready  = !ld_done && !waw_stall;
    assign ld_ready   = !in_wait;
    assign ld_accept  = ld_valid && !in_wait;
    assign alu_accept = alu_valid && alu_ready;

    load_align #(.XLEN(XLEN)) u_load_align (
        .funct3     (ld_funct3_p1),
        .offset     (ld_offset_p1),
        .rdata      (mem_rdata),
        .data       (fmt_data),
        .misaligned (fmt_mis)
    );

    // Stage p1: registered write port; a completing load owns the port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= WB_IDLE;
            ld_rd_p1     <= '0;
            ld_funct3_p1 <= '0;
            ld_offset_p1 <= '0;
            write_en     <= 1'b0;
            rd_addr      <= '0;
            rd_data      <= '0;
            busy_mask    <= '0;
            ld_err       <= 1'b0;
        end else begin
            write_en <= 1'b0;
            ld_err   <= mem_rvalid && !in_wait;

            if (ld_done) begin
                state               <= WB_IDLE;
                busy_mask[ld_rd_p1] <= 1'b0;
                if (fmt_mis) begin
                    ld_err <= 1'b1;
                end else if (ld_rd_p1 != '0) begin
                    write_en <= 1'b1;
                    rd_addr  <= ld_rd_p1;
                    rd_data  <= fmt_data;
                end
            end else if (alu_accept && (alu_rd != '0)) begin
                write_en <= 1'b1;
                rd_addr  <= alu_rd;
                rd_data  <= alu_data;
            end

            if (ld_accept) begin
                state        <= WB_WAIT_MEM;
                ld_rd_p1     <= ld_rd;
                ld_funct3_p1 <= ld_funct3;
                ld_offset_p1 <= ld_offset;
                if (ld_rd != '0)
                    busy_mask[ld_rd] <= 1'b1;
            end
        end
    end

`ifdef WB_FWD_EN
    assign r1_fwd_valid = write_en && (rd_addr == r1_addr) && (r1_addr != '0);
    assign r2_fwd_valid = write_en && (rd_addr == r2_addr) && (r2_addr != '0);
    assign r1_fwd_data  = rd_data;
    assign r2_fwd_data  = rd_data;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed writes and loads queue their
// expected regfile writes / ld_err pulses; a negedge monitor checks them.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        write_en;
    logic [31:0] busy_mask;
    logic        ld_err;
`ifdef WB_FWD_EN
    logic [4:0]  r1_addr = 5'd0;
    logic [4:0]  r2_addr = 5'd0;
    logic        r1_fwd_valid, r2_fwd_valid;
    logic [31:0] r1_fwd_data, r2_fwd_data;
`endif

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_funct3  (ld_funct3),
        .ld_offset  (ld_offset),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
`ifdef WB_FWD_EN
        .r1_addr      (r1_addr),
        .r2_addr      (r2_addr),
        .r1_fwd_valid (r1_fwd_valid),
        .r2_fwd_valid (r2_fwd_valid),
        .r1_fwd_data  (r1_fwd_data),
        .r2_fwd_data  (r2_fwd_data),
`endif
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .write_en   (write_en),
        .busy_mask  (busy_mask),
        .ld_err     (ld_err)
    );

    typedef struct {
        logic        is_err;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.is_err = 1'b0; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1; e.addr = '0; e.data = '0;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_offset = off;
        cyc();
        ld_valid = 1'b0;
    endtask

    task automatic mem_return(input logic [31:0] d);
        mem_rvalid = 1'b1; mem_rdata = d;
        cyc();
        mem_rvalid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (write_en) begin
                if (sb.size() == 0) begin
                    check("unexpected write_en", {31'd0, write_en}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("write kind", 32'd0, {31'd0, mon_e.is_err});
                    check("rd_addr", {27'd0, rd_addr}, {27'd0, mon_e.addr});
                    check("rd_data", rd_data, mon_e.data);
                end
            end
            if (ld_err) begin
                if (sb.size() == 0) begin
                    check("unexpected ld_err", {31'd0, ld_err}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ld_err kind", 32'd1, {31'd0, mon_e.is_err});
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_offset = 0;
        mem_rvalid = 0; mem_rdata = 0;
        #12;
        check("reset write_en", {31'd0, write_en}, 32'd0);
        check("reset rd_addr", {27'd0, rd_addr}, 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        check("reset busy_mask", busy_mask, 32'd0);
        check("reset ld_err", {31'd0, ld_err}, 32'd0);
        check("reset ld_ready", {31'd0, ld_ready}, 32'd1);
        cyc();
        rst = 1'b1;
        cyc();

        // ALU write rd=5
`ifdef WB_FWD_EN
        r1_addr = 5'd5; r2_addr = 5'd0;
`endif
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        push_wr(5'd5, 32'hDEADBEEF);
        cyc();
        alu_valid = 0;
        check("alu write_en", {31'd0, write_en}, 32'd1);
`ifdef WB_FWD_EN
        check("r1_fwd_valid", {31'd0, r1_fwd_valid}, 32'd1);
        check("r1_fwd_data", r1_fwd_data, 32'hDEADBEEF);
        check("r2_fwd_valid x0", {31'd0, r2_fwd_valid}, 32'd0);
`endif
        cyc();
        check("alu write_en drop", {31'd0, write_en}, 32'd0);

        // LB rd=7 offset 3, busy tracking
        issue_load(5'd7, 3'b000, 2'd3);
        check("LB busy issue", busy_mask, 32'h0000_0080);
        check("LB ld_ready", {31'd0, ld_ready}, 32'd0);
        cyc();
        check("LB busy hold", busy_mask, 32'h0000_0080);
        mem_rvalid = 1; mem_rdata = 32'h80FF_FF7F;
        push_wr(5'd7, 32'hFFFF_FF80);
        #1 check("alu_ready on load return", {31'd0, alu_ready}, 32'd0);
        cyc();
        mem_rvalid = 0;
        check("LB busy cleared", busy_mask, 32'd0);
        cyc();

        // LHU rd=9 offset 2
        issue_load(5'd9, 3'b101, 2'd2);
        push_wr(5'd9, 32'h0000_BEEF);
        mem_return(32'hBEEF_1234);
        cyc();

        // LH rd=4 offset 0 sign-extends; LBU rd=4 offset 1 zero-extends
        issue_load(5'd4, 3'b001, 2'd0);
        push_wr(5'd4, 32'hFFFF_8001);
        mem_return(32'h0000_8001);
        issue_load(5'd4, 3'b100, 2'd1);
        push_wr(5'd4, 32'h0000_00A5);
        mem_return(32'h0000_A500);
        cyc();

        // Misaligned LW rd=10 offset 1
        issue_load(5'd10, 3'b010, 2'd1);
        check("LW mis busy", busy_mask, 32'h0000_0400);
        push_err();
        mem_return(32'h1111_1111);
        check("LW mis busy cleared", busy_mask, 32'd0);
        cyc();

        // Load return collides with ALU rd=3
        issue_load(5'd12, 3'b010, 2'd0);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h0000_0033;
        mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        #1 check("collision alu_ready", {31'd0, alu_ready}, 32'd0);
        push_wr(5'd12, 32'h1234_5678);
        cyc();
        mem_rvalid = 0;
        #1 check("post-collision alu_ready", {31'd0, alu_ready}, 32'd1);
        push_wr(5'd3, 32'h0000_0033);
        cyc();
        alu_valid = 0;
        cyc();

        // WAW stall against pending rd=14, other rd proceeds
        issue_load(5'd14, 3'b010, 2'd0);
        alu_valid = 1; alu_rd = 14; alu_data = 32'hAAAA_0000;
        #1 check("WAW alu_ready", {31'd0, alu_ready}, 32'd0);
        alu_rd = 15; alu_data = 32'h0000_0F0F;
        #1 check("non-WAW alu_ready", {31'd0, alu_ready}, 32'd1);
        push_wr(5'd15, 32'h0000_0F0F);
        cyc();
        alu_valid = 0;
        push_wr(5'd14, 32'hCAFE_F00D);
        mem_return(32'hCAFE_F00D);
        cyc();

        // Simultaneous ALU and load accept in IDLE
        alu_valid = 1; alu_rd = 6; alu_data = 32'h0000_0066;
        push_wr(5'd6, 32'h0000_0066);
        issue_load(5'd8, 3'b010, 2'd0);
        alu_valid = 0;
        push_wr(5'd8, 32'h8888_8888);
        mem_return(32'h8888_8888);
        cyc();

        // x0 destinations never write or mark busy
        alu_valid = 1; alu_rd = 0; alu_data = 32'h5555_5555;
        cyc();
        alu_valid = 0;
        issue_load(5'd0, 3'b010, 2'd0);
        check("x0 busy", busy_mask, 32'd0);
        mem_return(32'h7777_7777);
        cyc();

        // Reset during WAIT_MEM, then a stray mem_rvalid
        issue_load(5'd11, 3'b010, 2'd0);
        #2 rst = 1'b0;
        #1 check("mid-reset busy", busy_mask, 32'd0);
        check("mid-reset ld_ready", {31'd0, ld_ready}, 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        push_err();
        mem_return(32'h2222_2222);
        cyc();
        cyc();

        check("scoreboard drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
